seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu_pkg.sv | 18 +
 rtl/seq_alu_core.sv | 31 +++
 rtl/seq_alu.sv | 83 ++++++++
 tb/tb_seq_alu.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: opcode and state encodings shared by the sequential ALU and its core.
package seq_alu_pkg;
  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_XOR  = 3'b001,
    OP_ADD  = 3'b010,
    OP_ROL  = 3'b011,
    OP_SUB  = 3'b100,
    OP_OR   = 3'b101,
    OP_MUL  = 3'b110,
    OP_PASS = 3'b111
  } op_e;
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MUL_RUN = 2'd1,
    S_DONE    = 2'd2
  } state_e;
endpackage

// File: rtl/seq_alu_core.sv
// seq_alu_core: combinational single-cycle ALU ops with carry/borrow/rotate-out flag.
module seq_alu_core
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  op_e              i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_y,
  output logic             o_co
);
  logic [WIDTH:0] w_add, w_sub;
  assign w_add = {1'b0, i_a} + {1'b0, i_b};
  assign w_sub = {1'b0, i_a} - {1'b0, i_b};
  // MUL is produced by the sequential shift-add in the top; here it yields zero.
  always_comb begin
    o_y  = '0;
    o_co = 1'b0;
    case (i_op)
      OP_AND:  o_y = i_a & i_b;
      OP_XOR:  o_y = i_a ^ i_b;
      OP_ADD:  {o_co, o_y} = w_add;
      OP_ROL:  {o_co, o_y} = {i_a, i_a[WIDTH-1]};
      OP_SUB:  {o_co, o_y} = w_sub;
      OP_OR:   o_y = i_a | i_b;
      OP_PASS: o_y = i_a;
      default: o_y = '0;
    endcase
  end
endmodule

// File: rtl/seq_alu.sv
// seq_alu: sequential ALU; single-cycle ops via seq_alu_core, WIDTH-cycle shift-add multiply.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       InsSel,
  input  logic [WIDTH-1:0] ALUinA,
  input  logic [WIDTH-1:0] ALUinB,
  output logic [WIDTH-1:0] ALUout,
  output logic             CO,
  output logic             Z,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_e r_state, w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [WIDTH-1:0] r_a, w_y;
  logic [2*WIDTH-1:0] r_prod, w_prod_nxt;
  logic [WIDTH:0] w_sum;
  logic w_co, w_is_mul, w_last;
  assign w_is_mul = op_e'(InsSel) == OP_MUL;
  assign w_last   = r_cnt == LAST;
  // Product register holds {partial sum, remaining multiplier bits}; one bit retired per cycle.
  assign w_sum      = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_a} : '0);
  assign w_prod_nxt = {w_sum, r_prod[WIDTH-1:1]};
  seq_alu_core #(.WIDTH(WIDTH)) u_core (
    .i_op (op_e'(InsSel)),
    .i_a  (ALUinA),
    .i_b  (ALUinB),
    .o_y  (w_y),
    .o_co (w_co)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end
  always_comb begin
    w_state_nxt = S_IDLE;
    case (r_state)
      S_IDLE:    w_state_nxt = start ? (w_is_mul ? S_MUL_RUN : S_DONE) : S_IDLE;
      S_MUL_RUN: w_state_nxt = w_last ? S_DONE : S_MUL_RUN;
      default:   w_state_nxt = S_IDLE;
    endcase
  end
  always_comb begin
    busy = r_state != S_IDLE;
    done = r_state == S_DONE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_a    <= '0;
      r_prod <= '0;
      ALUout <= '0;
      CO     <= 1'b0;
      Z      <= 1'b1;
    end else if (r_state == S_IDLE && start) begin
      if (w_is_mul) begin
        r_a    <= ALUinA;
        r_prod <= {{WIDTH{1'b0}}, ALUinB};
        r_cnt  <= '0;
      end else begin
        ALUout <= w_y;
        CO     <= w_co;
        Z      <= ~|w_y;
      end
    end else if (r_state == S_MUL_RUN) begin
      r_prod <= w_prod_nxt;
      r_cnt  <= r_cnt + CW'(1);
      if (w_last) begin
        ALUout <= w_prod_nxt[WIDTH-1:0];
        CO     <= |w_prod_nxt[2*WIDTH-1:WIDTH];
        Z      <= ~|w_prod_nxt[WIDTH-1:0];
      end
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: table-driven directed checks of seq_alu plus multi-cycle MUL/reset sequences.
module tb_seq_alu;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] InsSel = 3'd0;
  logic [7:0] ALUinA = 8'd0, ALUinB = 8'd0;
  logic [7:0] ALUout;
  logic       CO, Z, busy, done;
  int n_pass = 0, n_tot = 0;

  localparam logic [2:0] AND_ = 3'b000, XOR_ = 3'b001, ADD_ = 3'b010, ROL_ = 3'b011;
  localparam logic [2:0] SUB_ = 3'b100, OR_ = 3'b101, MUL_ = 3'b110, PASS_ = 3'b111;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a, b, y;
    logic       co, z;
  } vec_t;
  vec_t v[14];

  seq_alu #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .InsSel(InsSel),
    .ALUinA(ALUinA), .ALUinB(ALUinB), .ALUout(ALUout),
    .CO(CO), .Z(Z), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] y, input logic co, input logic z);
    int j;
    @(negedge clk);
    InsSel = op; ALUinA = a; ALUinB = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    j = 0;
    while (!done && j < 40) begin
      @(negedge clk);
      j++;
    end
    chk($sformatf("latency op%0d", op), j + 1, (op == MUL_) ? 9 : 1);
    chk($sformatf("ALUout op%0d %h,%h", op, a, b), ALUout, y);
    chk($sformatf("CO op%0d %h,%h", op, a, b), CO, co);
    chk($sformatf("Z op%0d %h,%h", op, a, b), Z, z);
    @(negedge clk);
    chk("done one cycle", done, 1'b0);
    chk("busy after done", busy, 1'b0);
  endtask

  initial begin
    int ndone, lat;
    v[0]  = '{ADD_,  8'hF0, 8'h20, 8'h10, 1'b1, 1'b0};
    v[1]  = '{SUB_,  8'h05, 8'h05, 8'h00, 1'b0, 1'b1};
    v[2]  = '{SUB_,  8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
    v[3]  = '{ROL_,  8'h81, 8'h00, 8'h03, 1'b1, 1'b0};
    v[4]  = '{MUL_,  8'h0C, 8'h0B, 8'h84, 1'b0, 1'b0};
    v[5]  = '{MUL_,  8'h10, 8'h10, 8'h00, 1'b1, 1'b1};
    v[6]  = '{AND_,  8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0};
    v[7]  = '{XOR_,  8'hAA, 8'hAA, 8'h00, 1'b0, 1'b1};
    v[8]  = '{OR_,   8'h0F, 8'hA0, 8'hAF, 1'b0, 1'b0};
    v[9]  = '{PASS_, 8'h5A, 8'hFF, 8'h5A, 1'b0, 1'b0};
    v[10] = '{ADD_,  8'hFF, 8'h01, 8'h00, 1'b1, 1'b1};
    v[11] = '{MUL_,  8'hFF, 8'hFF, 8'h01, 1'b1, 1'b0};
    v[12] = '{ROL_,  8'h7F, 8'h00, 8'hFE, 1'b0, 1'b0};
    v[13] = '{SUB_,  8'h80, 8'h01, 8'h7F, 1'b0, 1'b0};

    #12;
    chk("reset ALUout", ALUout, 8'h00);
    chk("reset CO", CO, 1'b0);
    chk("reset Z", Z, 1'b1);
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 14; i++)
      run_op(v[i].op, v[i].a, v[i].b, v[i].y, v[i].co, v[i].z);

    // MUL with inputs and start toggling mid-run: result, timing and single done unaffected
    run_op(PASS_, 8'h77, 8'h00, 8'h77, 1'b0, 1'b0);
    @(negedge clk);
    InsSel = MUL_; ALUinA = 8'h10; ALUinB = 8'h10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0; lat = 0;
    for (int j = 0; j < 14; j++) begin
      if (j == 3) begin
        chk("hold ALUout mid MUL", ALUout, 8'h77);
        chk("busy mid MUL", busy, 1'b1);
      end
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          lat = j + 1;
          chk("toggled MUL ALUout", ALUout, 8'h00);
          chk("toggled MUL CO", CO, 1'b1);
          chk("toggled MUL Z", Z, 1'b1);
        end
      end
      if (j >= 1 && j <= 6) begin
        ALUinA = 8'($urandom); ALUinB = 8'($urandom);
        InsSel = 3'($urandom); start = j[0];
      end else start = 1'b0;
      @(negedge clk);
    end
    chk("toggled MUL done count", ndone, 1);
    chk("toggled MUL latency", lat, 9);

    // Reset at cycle 4 of a MUL
    run_op(ADD_, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0);
    @(negedge clk);
    InsSel = MUL_; ALUinA = 8'h0C; ALUinB = 8'h0B; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("busy before mid reset", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid reset ALUout", ALUout, 8'h00);
    chk("mid reset CO", CO, 1'b0);
    chk("mid reset Z", Z, 1'b1);
    chk("mid reset busy", busy, 1'b0);
    chk("mid reset done", done, 1'b0);
    InsSel = ADD_; ALUinA = 8'h01; ALUinB = 8'h01; start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    ndone = 0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    chk("no activity after reset", ndone, 0);
    chk("ALUout held after reset", ALUout, 8'h00);
    run_op(ADD_, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
